// File: rtl/adder_iterative_if.sv
// Operand/result stream bundle for adder_iterative.
// With ADDER_ITERATIVE_SUB_EN defined, the bundle also carries the 1-bit
// op select (1 = subtract, 0 = add).
interface adder_iterative_if #(
  parameter int NBITS = 32
);
  logic             istream_val;
  logic             istream_rdy;
  logic [NBITS-1:0] in0;
  logic [NBITS-1:0] in1;
  logic             cin;
`ifdef ADDER_ITERATIVE_SUB_EN
  logic             op;
`endif
  logic             ostream_val;
  logic             ostream_rdy;
  logic [NBITS-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer/consumer side: drives operands and accepts results.
  modport master (
`ifdef ADDER_ITERATIVE_SUB_EN
    output op,
`endif
    output istream_val, in0, in1, cin, ostream_rdy,
    input  istream_rdy, ostream_val, sum, cout, ovf
  );

  // Adder side.
  modport slave (
`ifdef ADDER_ITERATIVE_SUB_EN
    input  op,
`endif
    input  istream_val, in0, in1, cin, ostream_rdy,
    output istream_rdy, ostream_val, sum, cout, ovf
  );
endinterface

// File: rtl/adder_iterative.sv
// Iterative adder: adds two NBITS operands CHUNK bits per cycle, so a result
// appears NBITS/CHUNK cycles after the operands are accepted.
// Optional feature: define ADDER_ITERATIVE_SUB_EN to add the op input
// (op = 1 computes in0 - in1 as in0 + ~in1 + 1, ignoring cin).
module adder_iterative #(
  parameter int NBITS = 32,
  parameter int CHUNK = 8
) (
  input  logic              clk,
  input  logic              rst,
  adder_iterative_if.slave  bus
);

  localparam int N  = NBITS / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] a_q, b_q;        // latched in0 and effective in1
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [NBITS-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic             accept;
  logic             sub;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;

`ifdef ADDER_ITERATIVE_SUB_EN
  assign sub = bus.op;
`else
  assign sub = 1'b0;
`endif

  assign accept = bus.istream_val && (state_q == IDLE);

  // Select chunk cnt_q of both latched operands and add it with the carry.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CW'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  end

  // Next-state logic for the accept / iterate / hand-off sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.istream_val) state_d = CALC;
      CALC:    if (cnt_q == LAST)   state_d = DONE;
      DONE:    if (bus.ostream_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture, chunk-wise sum write-back and final flag update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      // Subtraction is folded in here: the inverted operand and forced
      // carry-in make CALC identical for both operations.
      a_q     <= bus.in0;
      b_q     <= sub ? ~bus.in1 : bus.in1;
      carry_q <= sub ? 1'b1 : bus.cin;
      cnt_q   <= '0;
    end else if (state_q == CALC) begin
      for (int k = 0; k < N; k++) begin
        if (cnt_q == CW'(k)) sum_q[k*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
      end
      carry_q <= chunk_sum[CHUNK];
      if (cnt_q == LAST) begin
        // Counter holds on the last chunk so it can never step past it.
        cout_q <= chunk_sum[CHUNK];
        ovf_q  <= (a_q[NBITS-1] == b_q[NBITS-1]) &&
                  (chunk_sum[CHUNK-1] != a_q[NBITS-1]);
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.istream_rdy = (state_q == IDLE);
  assign bus.ostream_val = (state_q == DONE);
  assign bus.sum         = sum_q;
  assign bus.cout        = cout_q;
  assign bus.ovf         = ovf_q;

endmodule
